// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and constants for the arbitrated adder
package adder_arb_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit at or after ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] j;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequenced access to one shared WIDTH-bit adder
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        rsp_id,
    output logic [CNT_W-1:0]      done_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [IDW-1:0]   id;
    } result_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    result_t          res;
    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic [WIDTH-1:0] a_lane [NREQ];
    logic [WIDTH-1:0] b_lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_lane[i] = req_a[i*WIDTH +: WIDTH];
        assign b_lane[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Gated by rst so a held reset never advertises acceptance.
    assign req_ready = (state == IDLE && !rst) ? pick_grant : '0;

    assign ptr_next  = (res.id == IDW'(NREQ - 1)) ? '0 : res.id + 1'b1;

    assign rsp_sum   = res.sum;
    assign rsp_carry = res.carry;
    assign rsp_id    = res.id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            rsp_valid <= 1'b0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        op_a  <= a_lane[pick_idx];
                        op_b  <= b_lane[pick_idx];
                        op_id <= pick_idx;
                        state <= CALC;
                    end
                end
                CALC: begin
                    {res.carry, res.sum} <= {1'b0, op_a} + {1'b0, op_b};
                    res.id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ptr_next;
                        done_cnt  <= done_cnt + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic [1:0]  rsp_id;
    logic [15:0] done_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  la [4];
    logic [7:0]  lb [4];
    int          exp_ptr;
    logic [15:0] exp_done;

    typedef struct {
        logic [3:0] v;
        logic [7:0] a;
        logic [7:0] b;
        int         delay;
        int         eg;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs [6];

    adder_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        logic [1:0] k;
        for (int i = 0; i < 4; i++) begin
            k = 2'((p + i) % 4);
            if (v[k]) return int'(k);
        end
        return -1;
    endfunction

    task automatic drive_lanes();
        req_a = {la[3], la[2], la[1], la[0]};
        req_b = {lb[3], lb[2], lb[1], lb[0]};
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 4; i++) begin
            la[i] = 8'($urandom_range(0, 255));
            lb[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Called at posedge+1 while the DUT is idle; returns at posedge+1 after completion.
    task automatic txn(input logic [3:0] v, input int delay, input int eg,
                       input logic [7:0] es, input logic ec);
        logic [3:0] m;
        m = 4'b0001 << eg;
        req_valid = v;
        drive_lanes();
        rsp_ready = (delay == 0);
        #1;
        check("grant", 32'(req_ready), 32'(m));
        @(posedge clk); #1;
        check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("calc_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_sum", 32'(rsp_sum), 32'(es));
        check("rsp_carry", 32'(rsp_carry), 32'(ec));
        check("rsp_id", 32'(rsp_id), 32'(eg));
        for (int k = 0; k < delay; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_sum", 32'(rsp_sum), 32'(es));
            check("hold_id", 32'(rsp_id), 32'(eg));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_done = exp_done + 16'd1;
        exp_ptr  = (eg + 1) % 4;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_cnt", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        vecs[0] = '{4'b0010, 8'h12, 8'h34, 0, 1, 8'h46, 1'b0};
        vecs[1] = '{4'b0001, 8'hFF, 8'h01, 0, 0, 8'h00, 1'b1};
        vecs[2] = '{4'b1000, 8'h80, 8'h80, 5, 3, 8'h00, 1'b1};
        vecs[3] = '{4'b0110, 8'h7F, 8'h01, 0, 1, 8'h80, 1'b0};
        vecs[4] = '{4'b0011, 8'hA5, 8'h5A, 1, 0, 8'hFF, 1'b0};
        vecs[5] = '{4'b1111, 8'hC8, 8'h64, 2, 1, 8'h2C, 1'b1};

        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        rand_lanes();
        drive_lanes();
        exp_ptr   = 0;
        exp_done  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        req_valid = 4'h0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_req", 32'(req_ready), 32'd0);

        foreach (vecs[i]) begin
            rand_lanes();
            la[vecs[i].eg] = vecs[i].a;
            lb[vecs[i].eg] = vecs[i].b;
            txn(vecs[i].v, vecs[i].delay, vecs[i].eg, vecs[i].es, vecs[i].ec);
        end

        // All requesters valid, rsp_ready high: one grant every 3 cycles, rotating.
        begin
            int p0;
            logic [3:0] m;
            p0 = exp_ptr;
            req_valid = 4'hF;
            rsp_ready = 1'b1;
            #1;
            for (int c = 0; c < 15; c++) begin
                m = (c % 3 == 0) ? (4'b0001 << ((p0 + c / 3) % 4)) : 4'b0000;
                check("rr_grant", 32'(req_ready), 32'(m));
                @(posedge clk); #1;
            end
            req_valid = 4'h0;
            exp_ptr  = (p0 + 5) % 4;
            exp_done = exp_done + 16'd5;
            check("rr_done_cnt", 32'(done_cnt), 32'(exp_done));
        end

        for (int n = 0; n < 150; n++) begin
            logic [3:0] v;
            int g;
            int t;
            v = 4'($urandom_range(0, 15));
            rand_lanes();
            if (v == 4'h0) begin
                req_valid = 4'h0;
                drive_lanes();
                #1;
                check("rand_idle_ready", 32'(req_ready), 32'd0);
                @(posedge clk); #1;
                check("rand_idle_valid", 32'(rsp_valid), 32'd0);
            end else begin
                g = pick(v, exp_ptr);
                t = int'(la[g]) + int'(lb[g]);
                txn(v, int'($urandom_range(0, 3)), g, t[7:0], t[8]);
            end
        end

        // Reset while in CALC aborts the transaction; first grant afterwards is requester 0.
        rand_lanes();
        req_valid = 4'b0100;
        drive_lanes();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'b0101;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_sum", 32'(rsp_sum), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_done", 32'(done_cnt), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ptr  = 0;
        exp_done = 16'd0;
        la[0] = 8'h11;
        lb[0] = 8'h22;
        txn(4'b0101, 0, 0, 8'h33, 1'b0);

        force dut.done_cnt = 16'hFFFF;
        #1;
        release dut.done_cnt;
        exp_done = 16'hFFFF;
        la[3] = 8'h01;
        lb[3] = 8'h02;
        txn(4'b1000, 0, 3, 8'h03, 1'b0);
        req_valid = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
